// File: rtl/post_lna_deframer_pkg.sv
// Shared types and constants for the post-LNA receive deframer.
// FSM state codes, default sync pattern and saturating counter helper.
package post_lna_pkg;
  localparam int CntWidth = 8;
  localparam int DefSyncWidth = 8;
  localparam logic [DefSyncWidth-1:0] DefSyncWord = 8'hA5;

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;

  function automatic logic [CntWidth-1:0] sat_inc(
    input logic [CntWidth-1:0] v
  );
    return (v == '1) ? v : v + CntWidth'(1);
  endfunction
endpackage

// File: rtl/post_lna_deframer_if.sv
// Valid/ready word stream from the deframer to the back end.
// Carries the payload word and its first-of-frame flag.
interface post_lna_deframer_if #(
  parameter int Width = 8
);
  logic [Width-1:0] data;
  logic             first;
  logic             valid;
  logic             ready;

  modport master (output data, first, valid, input ready);
  modport slave  (input data, first, valid, output ready);
endinterface

// File: rtl/post_lna_deframer_fifo.sv
// Small synchronous word FIFO; a push into a full FIFO is accepted
// only when a pop retires the head in the same cycle.
module rx_word_fifo #(
  parameter int Width = 9,
  parameter int Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head is masked while empty so the idle output reads as zero.
  assign o_data = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/post_lna_deframer.sv
// Serial deframer: hunts for the sync word, deserializes payload
// words into a FIFO and tracks lock, sync losses and overflows.
module post_lna_deframer
  import post_lna_pkg::*;
#(
  parameter int WordWidth = 8,
  parameter int SyncWidth = DefSyncWidth,
  parameter logic [SyncWidth-1:0] SyncWord = DefSyncWord,
  parameter int WordsPerFrame = 16,
  parameter int FifoDepth = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 InnerReceive,
  input  logic                 SampleEnable,
  post_lna_deframer_if.master  rx,
  output logic                 Locked,
  output logic [CntWidth-1:0]  SyncLossCount,
  output logic [CntWidth-1:0]  OverflowCount
);
  localparam int BitMax = (WordWidth > SyncWidth) ? WordWidth : SyncWidth;
  localparam int BW  = $clog2(BitMax);
  localparam int WCW = $clog2(WordsPerFrame + 1);

  logic [1:0]           r_state;
  logic [SyncWidth-2:0] r_hist;
  logic [WordWidth-2:0] r_word;
  logic [BW-1:0]        r_bitcnt;
  logic [WCW-1:0]       r_wordcnt;

  logic [SyncWidth-1:0] w_hist_nxt;
  logic [WordWidth-1:0] w_word_nxt;
  logic                 w_last_word_bit;
  logic                 w_last_sync_bit;
  logic                 w_last_word;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [WordWidth:0]   w_head;

  assign w_hist_nxt = {r_hist, InnerReceive};
  assign w_word_nxt = {r_word, InnerReceive};

  assign w_last_word_bit = (r_bitcnt == BW'(WordWidth - 1));
  assign w_last_sync_bit = (r_bitcnt == BW'(SyncWidth - 1));
  assign w_last_word     = (r_wordcnt == WCW'(WordsPerFrame - 1));

  assign w_push = SampleEnable && (r_state == PAYLOAD) && w_last_word_bit;
  assign w_pop  = rx.valid && rx.ready;

  rx_word_fifo #(
    .Width (WordWidth + 1),
    .Depth (FifoDepth)
  ) u_fifo (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_push  (w_push),
    .i_data  ({(r_wordcnt == '0), w_word_nxt}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rx.data  = w_head[WordWidth-1:0];
  assign rx.first = w_head[WordWidth];
  assign rx.valid = !w_empty;
  assign Locked   = (r_state != HUNT);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= HUNT;
      r_hist        <= '0;
      r_word        <= '0;
      r_bitcnt      <= '0;
      r_wordcnt     <= '0;
      SyncLossCount <= '0;
      OverflowCount <= '0;
    end else begin
      if (w_push && w_full && !w_pop)
        OverflowCount <= sat_inc(OverflowCount);
      if (SampleEnable) begin
        unique case (r_state)
          HUNT: begin
            r_hist <= w_hist_nxt[SyncWidth-2:0];
            if (w_hist_nxt == SyncWord) begin
              r_state   <= PAYLOAD;
              r_bitcnt  <= '0;
              r_wordcnt <= '0;
            end
          end
          PAYLOAD: begin
            r_word <= w_word_nxt[WordWidth-2:0];
            if (w_last_word_bit) begin
              r_bitcnt  <= '0;
              r_wordcnt <= r_wordcnt + WCW'(1);
              if (w_last_word) begin
                r_state <= CHECK;
                r_hist  <= '0;
              end
            end else begin
              r_bitcnt <= r_bitcnt + BW'(1);
            end
          end
          CHECK: begin
            r_hist <= w_hist_nxt[SyncWidth-2:0];
            if (w_last_sync_bit) begin
              r_bitcnt <= '0;
              if (w_hist_nxt == SyncWord) begin
                r_state   <= PAYLOAD;
                r_wordcnt <= '0;
              end else begin
                // Lost alignment: restart the hunt from a clean history.
                r_state       <= HUNT;
                r_hist        <= '0;
                SyncLossCount <= sat_inc(SyncLossCount);
              end
            end else begin
              r_bitcnt <= r_bitcnt + BW'(1);
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_post_lna_deframer.sv
// Directed bench for post_lna_deframer: lock, noise, sync loss,
// overflow, full-FIFO push/pop, sparse sampling and mid-frame reset.
module tb_post_lna_deframer;
  logic       clk = 1'b0;
  logic       rst;
  logic       rxbit;
  logic       en;
  logic       locked;
  logic [7:0] sync_loss;
  logic [7:0] ovf;

  int n_err = 0;
  int n_checks = 0;

  logic [7:0] got_d [$];
  logic       got_f [$];
  logic [7:0] exp_d [$];
  logic       exp_f [$];

  post_lna_deframer_if #(.Width(8)) rx_bus ();

  post_lna_deframer dut (
    .Clock         (clk),
    .Reset         (rst),
    .InnerReceive  (rxbit),
    .SampleEnable  (en),
    .rx            (rx_bus),
    .Locked        (locked),
    .SyncLossCount (sync_loss),
    .OverflowCount (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && rx_bus.valid && rx_bus.ready) begin
      got_d.push_back(rx_bus.data);
      got_f.push_back(rx_bus.first);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic e);
    rxbit = b;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic sparse);
    for (int i = 7; i >= 0; i--) begin
      step(v[i], 1'b1);
      if (sparse) step(~v[i], 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic expect_frame(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(base + 8'(i));
      exp_f.push_back(i == 0);
    end
  endtask

  initial begin
    logic [7:0] a5;
    logic [7:0] w80;
    a5 = 8'hA5;
    rst = 1'b1;
    rxbit = 1'b0;
    en = 1'b0;
    rx_bus.ready = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0);
    chk("rst_valid", rx_bus.valid, 0);
    chk("rst_data", rx_bus.data, 0);
    chk("rst_first", rx_bus.first, 0);
    chk("rst_locked", locked, 0);
    chk("rst_syncloss", sync_loss, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    idle(2);

    // Lock on the sync word and stream one dense frame.
    for (int i = 7; i >= 1; i--) step(a5[i], 1'b1);
    chk("lock_before_last", locked, 0);
    step(a5[0], 1'b1);
    chk("lock_after_last", locked, 1);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    expect_frame(8'h00, 16);
    idle(3);
    chk("f1_count", got_d.size(), 16);
    chk("f1_locked_in_check", locked, 1);

    // Bad sync after the frame.
    send_byte(8'hA4, 1'b0);
    chk("loss_locked", locked, 0);
    chk("loss_count", sync_loss, 1);
    idle(2);
    chk("loss_no_words", got_d.size(), 16);

    // Noise, then a real sync and frame.
    send_byte(8'h5A, 1'b0);
    send_byte(8'h3C, 1'b0);
    chk("noise_unlocked", locked, 0);
    chk("noise_no_words", got_d.size(), 16);
    send_byte(8'hA5, 1'b0);
    chk("noise_relock", locked, 1);
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i), 1'b0);
    expect_frame(8'h40, 16);
    idle(3);
    chk("f2_count", got_d.size(), 32);

    // Back end stalled for a whole frame: 4 kept, 12 dropped.
    rx_bus.ready = 1'b0;
    send_byte(8'hA5, 1'b0);
    chk("resync_locked", locked, 1);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    expect_frame(8'h00, 4);
    chk("ovf_count", ovf, 12);
    chk("ovf_valid", rx_bus.valid, 1);
    chk("ovf_head", rx_bus.data, 8'h00);
    chk("ovf_head_first", rx_bus.first, 1);
    chk("ovf_no_pop", got_d.size(), 32);

    // Full FIFO: pop coincides with the completing word.
    send_byte(8'hA5, 1'b0);
    w80 = 8'h80;
    for (int i = 7; i >= 1; i--) step(w80[i], 1'b1);
    chk("full_before", ovf, 12);
    rx_bus.ready = 1'b1;
    step(w80[0], 1'b1);
    chk("full_pushpop_ovf", ovf, 12);
    chk("full_pushpop_head", rx_bus.data, 8'h01);
    for (int i = 1; i < 16; i++) send_byte(8'h80 + 8'(i), 1'b0);
    expect_frame(8'h80, 16);
    idle(3);
    chk("drain_count", got_d.size(), 52);
    chk("drain_ovf", ovf, 12);

    // Sparse sampling, stall, then reset mid-frame.
    send_byte(8'hA5, 1'b1);
    send_byte(8'hC0, 1'b1);
    send_byte(8'hC1, 1'b1);
    expect_frame(8'hC0, 2);
    rx_bus.ready = 1'b0;
    send_byte(8'hC2, 1'b1);
    send_byte(8'hC3, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("sparse_count", got_d.size(), 54);
    chk("sparse_head", rx_bus.data, 8'hC2);
    chk("sparse_head_first", rx_bus.first, 0);
    chk("sparse_locked", locked, 1);
    rst = 1'b1;
    step(1'b1, 1'b1);
    chk("mid_rst_valid", rx_bus.valid, 0);
    chk("mid_rst_data", rx_bus.data, 0);
    chk("mid_rst_first", rx_bus.first, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_syncloss", sync_loss, 0);
    chk("mid_rst_ovf", ovf, 0);
    rst = 1'b0;
    rx_bus.ready = 1'b1;
    idle(4);
    chk("post_rst_valid", rx_bus.valid, 0);

    chk("total_words", got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      chk($sformatf("word%0d_data", i),
          (i < got_d.size()) ? 32'(got_d[i]) : 32'hx, 32'(exp_d[i]));
      chk($sformatf("word%0d_first", i),
          (i < got_f.size()) ? 32'(got_f[i]) : 32'hx, 32'(exp_f[i]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/post_lna_deframer.md
# post_lna_deframer

Receive-side deframer directly downstream of the post-LNA path: it consumes the recovered serial bit on `InnerReceive`, hunts for a fixed sync word, deserializes the following payload into words and hands them to the digital back end over a valid/ready interface. It tracks frame lock and counts sync losses and FIFO overflows so the back end can monitor link health.

## Interface
- `WordWidth`, 8, payload word width in bits.
- `SyncWord`, 8'hA5, frame sync pattern, `SyncWidth` bits, MSB received first.
- `SyncWidth`, 8, sync pattern length in bits.
- `WordsPerFrame`, 16, payload words following each sync.
- `FifoDepth`, 4, output buffer depth in words; power of two, ≥2.

Ports:
- `Clock`  in  1  single clock.
- `Reset`  in  1  synchronous, active-high.
- `InnerReceive`  in  1  recovered serial bit from the post-LNA stage.
- `SampleEnable`  in  1  qualifies `InnerReceive`; one bit is consumed per cycle with `SampleEnable`=1.
- `RxData`  out  `WordWidth`  head-of-FIFO word.
- `RxFirst`  out  1  head word is the first word of its frame.
- `RxValid`  out  1  FIFO non-empty.
- `RxReady`  in  1  back end accepts the head word.
- `Locked`  out  1  deframer is in PAYLOAD or CHECK.
- `SyncLossCount`  out  8  saturating count of CHECK failures.
- `OverflowCount`  out  8  saturating count of dropped words.

## Operation
- States: HUNT, PAYLOAD, CHECK. Reset → HUNT.
- HUNT: each sampled bit shifts into a `SyncWidth` history register (new bit at LSB). When the updated history equals `SyncWord`, go to PAYLOAD; bit and word counters clear.
- PAYLOAD: sampled bits shift MSB-first into the word register. On the `WordWidth`-th bit, the completed word (with `RxFirst` = word counter==0) is pushed; word counter increments. After word `WordsPerFrame`-1 is pushed, go to CHECK, bit counter clears.
- CHECK: collect `SyncWidth` bits. If equal to `SyncWord` → PAYLOAD (new frame, no re-hunt). Otherwise → HUNT, history register cleared, `SyncLossCount` increments (saturate at 255).
- `Locked` = state != HUNT.
- FIFO: push on word completion; pop on `RxValid && RxReady`. Push while full without a same-cycle pop drops the incoming word and increments `OverflowCount` (saturate at 255). Push and pop in the same cycle while full: both succeed and the count is unchanged.
- Cycles with `SampleEnable`=0 change no deframing state; FIFO pops still proceed.
- `RxData`/`RxFirst` are stable while `RxValid`=1 and `RxReady`=0.

## Timing
- Reset values: `RxValid`=0, `RxData`=0, `RxFirst`=0, `Locked`=0, both counters 0, FIFO empty, state HUNT.
- Reset mid-frame discards all buffered words and partial words on the next edge.
- `Locked` rises the cycle after the clock edge that samples the last sync bit.
- Word latency: last payload bit sampled at edge N → `RxValid`=1 with that word (FIFO previously empty) after edge N, i.e. visible in cycle N+1.
- Pop takes effect at the edge where `RxValid && RxReady`; the next word (if any) is presented in the following cycle with no bubble.
- Full FIFO throughput: one word per cycle in and out.

## Structure
- Shared package `post_lna_pkg`: state enum (HUNT, PAYLOAD, CHECK), default `SyncWord`/`SyncWidth` constants, counter width constant (8).
- One sub-module `rx_word_fifo`: synchronous FIFO of `{RxFirst, RxData}` with push/pop/full/empty and same-cycle push-pop-when-full support. Deframer FSM and counters stay in the top module.

## Test plan
- Reset, then stream 0xA5 followed by 16 words 0x00..0x0F with `RxReady`=1 → `Locked` rises after the 8th bit; words 0x00..0x0F appear in order, `RxFirst`=1 only on 0x00.
- Noise 0x5A 0x3C then 0xA5 + frame → no words before the sync; first emitted word is the frame’s word 0.
- Frame followed by 0xA4 instead of 0xA5 → `Locked` falls, `SyncLossCount`=1, no words emitted until the next 0xA5.
- `RxReady`=0 for a whole frame → 4 words buffered (0x00..0x03), `OverflowCount`=12; releasing `RxReady` drains exactly 0x00..0x03.
- FIFO full with `RxReady`=1 on the cycle a word completes → word accepted, `OverflowCount` unchanged.
- `SampleEnable` toggled every other cycle during a frame, then `Reset` asserted mid-frame → identical words to the dense case before reset; all outputs return to reset values after the reset edge.
